mem_access_ctrl: RTL and testbench

- Sequencer for the LC-3 data-memory access stage: turns one load/store request from execute into the per-cycle mem_state / M_Control / M_Addr / M_Data drive of the memaccess datapath.
- Handles direct and indirect (LDI/STI) accesses, waits on a memory-ready handshake, captures load data, and stalls the pipeline while busy.
- Sits between the execute stage and memaccess.

---
 rtl/mem_access_ctrl.sv | 85 ++++++++
 tb/tb_mem_access_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one LC-3 load/store (direct or indirect) into per-cycle memaccess drive,
// waiting on dmem_ready with a per-phase timeout and stalling upstream while busy.
module mem_access_ctrl #(
    parameter int AW = 16,
    parameter int DW = 16,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req_valid,
    input  logic [1:0]    req_type,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_data,
    input  logic          dmem_ready,
    input  logic [DW-1:0] dmem_dout,
    output logic          req_ready,
    output logic [1:0]    mem_state,
    output logic          M_Control,
    output logic [AW-1:0] M_Addr,
    output logic [DW-1:0] M_Data,
    output logic          stall,
    output logic          done,
    output logic          err,
    output logic [DW-1:0] load_data
);
    // State encodings equal the mem_state code each state drives
    localparam logic [1:0] S_READ  = 2'd0;
    localparam logic [1:0] S_INDIR = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_IDLE  = 2'd3;
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    state;
    logic          to_write;
    logic [CW-1:0] wait_cnt;
    logic          timeout;

    assign req_ready = state == S_IDLE;
    assign stall     = !req_ready || req_valid;
    assign mem_state = state;
    assign M_Control = 1'b0;
    assign timeout   = !dmem_ready && wait_cnt == CW'(TIMEOUT_CYC - 1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            to_write  <= 1'b0;
            wait_cnt  <= '0;
            M_Addr    <= '0;
            M_Data    <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            load_data <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (state == S_IDLE) begin
                if (req_valid) begin
                    M_Addr   <= req_addr;
                    M_Data   <= req_data;
                    to_write <= req_type[1];
                    wait_cnt <= '0;
                    state    <= req_type == 2'b00 ? S_READ : req_type == 2'b10 ? S_WRITE : S_INDIR;
                end
            end else if (dmem_ready) begin
                wait_cnt <= '0;
                if (state == S_INDIR) begin
                    M_Addr <= dmem_dout;
                    state  <= to_write ? S_WRITE : S_READ;
                end else begin
                    if (state == S_READ) load_data <= dmem_dout;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
            end else if (timeout) begin
                done     <= 1'b1;
                err      <= 1'b1;
                wait_cnt <= '0;
                state    <= S_IDLE;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed stimulus pushes expected completions into a scoreboard;
// a negedge monitor pops and checks them whenever done is presented.
module tb_mem_access_ctrl;
    logic        clock = 0, reset = 1, req_valid = 0, dmem_ready = 0;
    logic [1:0]  req_type = 0;
    logic [15:0] req_addr = 0, req_data = 0, dmem_dout = 0;
    logic        req_ready, M_Control, stall, done, err;
    logic [1:0]  mem_state;
    logic [15:0] M_Addr, M_Data, load_data;

    typedef struct {logic err; logic [15:0] ld; int cyc;} exp_t;
    exp_t sb[$];
    exp_t e;
    int tests = 0, fails = 0, cyc = 0, k = 0;

    mem_access_ctrl #(.AW(16), .DW(16), .TIMEOUT_CYC(15)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_type(req_type),
        .req_addr(req_addr), .req_data(req_data), .dmem_ready(dmem_ready), .dmem_dout(dmem_dout),
        .req_ready(req_ready), .mem_state(mem_state), .M_Control(M_Control), .M_Addr(M_Addr),
        .M_Data(M_Data), .stall(stall), .done(done), .err(err), .load_data(load_data)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        tests++;
        if (a !== x) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, x, cyc);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] t, input logic [15:0] a, input logic [15:0] d,
                         input logic r, input logic [15:0] o);
        @(posedge clock);
        #1;
        req_valid = v; req_type = t; req_addr = a; req_data = d; dmem_ready = r; dmem_dout = o;
    endtask

    task automatic push(input logic er, input logic [15:0] ld, input int c);
        exp_t x;
        x.err = er; x.ld = ld; x.cyc = c;
        sb.push_back(x);
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (done) begin
                if (sb.size() == 0) chk("unexpected_done", sb.size(), 1);
                else begin
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("done_err", err, e.err);
                    chk("done_load_data", load_data, e.ld);
                end
            end else if (err) chk("err_without_done", done, err);
        end
    end

    initial begin
        @(negedge clock);
        chk("rst_mem_state", mem_state, 3);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_outputs", {M_Control, stall, done, err}, 0);
        chk("rst_addr_data", {M_Addr, M_Data}, 0);
        chk("rst_load_data", load_data, 0);
        @(posedge clock); #1 reset = 0;

        // direct load
        drive(1, 2'b00, 16'h3000, 16'h0, 1, 16'h1234); k = cyc; push(0, 16'h1234, k + 2);
        @(negedge clock); chk("dl_stall_accept", stall, 1); chk("dl_ms_idle", mem_state, 3);
        drive(0, 2'b00, 16'h3000, 16'h0, 1, 16'h1234);
        @(negedge clock); chk("dl_ms_read", mem_state, 0); chk("dl_addr", M_Addr, 16'h3000);
        chk("dl_stall_busy", stall, 1); chk("dl_not_ready", req_ready, 0);
        drive(0, 2'b00, 16'h0, 16'h0, 1, 16'h0);
        @(negedge clock); chk("dl_ms_back", mem_state, 3); chk("dl_stall_off", stall, 0);

        // indirect store
        drive(1, 2'b11, 16'h4000, 16'hBEEF, 1, 16'h5005); k = cyc; push(0, 16'h1234, k + 3);
        drive(0, 2'b00, 16'h0, 16'h0, 1, 16'h5005);
        @(negedge clock); chk("is_ms_indir", mem_state, 1); chk("is_addr_ptr", M_Addr, 16'h4000);
        chk("is_data", M_Data, 16'hBEEF); chk("is_mcontrol", M_Control, 0);
        drive(0, 2'b00, 16'h0, 16'h0, 1, 16'h7777);
        @(negedge clock); chk("is_ms_write", mem_state, 2); chk("is_addr_res", M_Addr, 16'h5005);
        chk("is_data_w", M_Data, 16'hBEEF);
        drive(0, 2'b00, 16'h0, 16'h0, 0, 16'h0);
        @(negedge clock);

        // indirect load with 4 wait states per phase
        drive(1, 2'b01, 16'h6000, 16'h0, 0, 16'hDEAD); k = cyc; push(0, 16'hCAFE, k + 11);
        for (int i = 0; i < 5; i++) begin
            drive(0, 2'b00, 16'h0, 16'h0, i == 4, i == 4 ? 16'h7000 : 16'hDEAD);
            @(negedge clock); chk("ws_ms_indir", mem_state, 1); chk("ws_addr_indir", M_Addr, 16'h6000);
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, 2'b00, 16'h0, 16'h0, i == 4, i == 4 ? 16'hCAFE : 16'hDEAD);
            @(negedge clock); chk("ws_ms_read", mem_state, 0); chk("ws_addr_read", M_Addr, 16'h7000);
        end
        drive(0, 2'b00, 16'h0, 16'h0, 0, 16'h0);
        @(negedge clock);

        // direct store timing out
        drive(1, 2'b10, 16'h8000, 16'h1111, 0, 16'h0); k = cyc; push(1, 16'hCAFE, k + 16);
        for (int i = 1; i <= 15; i++) begin
            drive(0, 2'b00, 16'h0, 16'h0, 0, 16'h0);
            @(negedge clock);
            if (i == 1 || i == 15) chk("to_ms_write", mem_state, 2);
        end
        drive(0, 2'b00, 16'h0, 16'h0, 0, 16'h0);
        @(negedge clock); chk("to_req_ready", req_ready, 1); chk("to_ms_idle", mem_state, 3);

        // back-to-back with changed inputs while busy
        drive(1, 2'b00, 16'h3100, 16'h0, 1, 16'h4242); k = cyc; push(0, 16'h4242, k + 2);
        @(negedge clock); chk("bb_stall", stall, 1);
        drive(1, 2'b00, 16'h9999, 16'h0, 1, 16'h4242);
        @(negedge clock); chk("bb_addr_held", M_Addr, 16'h3100);
        drive(1, 2'b10, 16'h3200, 16'h5555, 1, 16'h0); push(0, 16'h4242, k + 4);
        @(negedge clock); chk("bb_ready_done", req_ready, 1); chk("bb_stall_idle", stall, 1);
        drive(0, 2'b00, 16'h0, 16'h0, 1, 16'h0);
        @(negedge clock); chk("bb_ms_write", mem_state, 2); chk("bb_addr2", M_Addr, 16'h3200);
        chk("bb_data2", M_Data, 16'h5555);
        drive(0, 2'b00, 16'h0, 16'h0, 0, 16'h0);
        @(negedge clock);

        // reset in the middle of an indirect access
        drive(1, 2'b01, 16'hA000, 16'h0, 0, 16'h0);
        drive(0, 2'b00, 16'h0, 16'h0, 0, 16'h0);
        @(negedge clock); chk("rm_ms_indir", mem_state, 1);
        drive(0, 2'b00, 16'h0, 16'h0, 0, 16'h0);
        #2 reset = 1;
        @(negedge clock);
        chk("rm_ms", mem_state, 3); chk("rm_ready", req_ready, 1);
        chk("rm_addr_data", {M_Addr, M_Data}, 0); chk("rm_load_data", load_data, 0);
        chk("rm_flags", {stall, done, err}, 0);
        @(posedge clock); #1 reset = 0;
        drive(1, 2'b00, 16'h3000, 16'h0, 1, 16'h0ABC); k = cyc; push(0, 16'h0ABC, k + 2);
        drive(0, 2'b00, 16'h0, 16'h0, 1, 16'h0ABC);
        @(negedge clock); chk("rm_after_ms", mem_state, 0);
        repeat (3) drive(0, 2'b00, 16'h0, 16'h0, 0, 16'h0);
        @(negedge clock);
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
